cos_batch_driver: RTL and testbench

Initiator-side sequencer for the cosine series core's start/done handshake. It buffers incoming 16-bit arguments in a small FIFO and issues them one at a time to the core (`start`, `xBus`). It waits for `done`, captures the 18-bit `rBus` result and presents it downstream on a valid/ready port. It sits between the sample source and the cosine core, so the core can be fed back-to-back without the source knowing its variable latency.

---
 rtl/cos_batch_driver.sv | 121 ++++++++++++
 tb/tb_cos_batch_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cos_batch_driver.sv
// Start/done sequencer for the cosine series core: FIFO-buffered arguments in, one core
// transaction at a time, results out on a valid/ready port. Optional COS_BATCH_TIMEOUT_EN.
module cos_batch_driver #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] inX,
  output logic        coreStart,
  output logic [15:0] coreX,
  input  logic        coreDone,
  input  logic [17:0] coreR,
  output logic        outValid,
  input  logic        outReady,
  output logic [17:0] outR,
  output logic [15:0] outX,
  output logic        busy,
  output logic        timeoutErr
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e      state;
  logic [15:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic        full, empty, push, issue;
  logic [15:0] headX;

  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign empty   = (wrPtr == rdPtr);
  assign inReady = !full;
  assign push    = inValid && !full;
  assign headX   = mem[rdPtr[AW-1:0]];
  assign busy    = (state != StIdle) || !empty;

  // The head is popped and latched on the edge into StIssue, so coreX is valid with the pulse.
  assign issue = !empty && ((state == StIdle) || ((state == StHold) && outReady));

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= inX;
  end

`ifdef COS_BATCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CntW-1:0] waitCnt;
  logic            timeoutQ;
  assign timeoutErr = timeoutQ;
`else
  assign timeoutErr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      wrPtr     <= '0;
      rdPtr     <= '0;
      coreStart <= 1'b0;
      coreX     <= '0;
      outValid  <= 1'b0;
      outR      <= '0;
      outX      <= '0;
`ifdef COS_BATCH_TIMEOUT_EN
      waitCnt   <= '0;
      timeoutQ  <= 1'b0;
`endif
    end else begin
      coreStart <= 1'b0;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (issue) begin
        rdPtr     <= rdPtr + 1'b1;
        coreX     <= headX;
        coreStart <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (!empty) state <= StIssue;
        end
        StIssue: begin
`ifdef COS_BATCH_TIMEOUT_EN
          waitCnt <= '0;
`endif
          state <= StWait;
        end
        StWait: begin
`ifdef COS_BATCH_TIMEOUT_EN
          waitCnt <= waitCnt + 1'b1;
`endif
          if (coreDone) begin
            outR     <= coreR;
            outX     <= coreX;
            outValid <= 1'b1;
            state    <= StHold;
          end
`ifdef COS_BATCH_TIMEOUT_EN
          // A done arriving on the limit cycle wins via the branch above.
          else if (waitCnt == CntW'(TIMEOUT - 1)) begin
            outR     <= '1;
            outX     <= coreX;
            outValid <= 1'b1;
            timeoutQ <= 1'b1;
            state    <= StHold;
          end
`endif
        end
        StHold: begin
          if (outReady) begin
            outValid <= 1'b0;
            state    <= empty ? StIdle : StIssue;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cos_batch_driver.sv
// Randomized bench for cos_batch_driver: a 12-cycle core model, a queue-based reference of
// argument order and handshake timing, and a few hand-computed literal expectations.
module tb_cos_batch_driver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic        clk, rst, inValid, inReady, coreStart, coreDone, outValid, outReady;
  logic        busy, timeoutErr;
  logic [15:0] inX, coreX, outX;
  logic [17:0] coreR, outR;

  cos_batch_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .inX(inX),
    .coreStart(coreStart), .coreX(coreX), .coreDone(coreDone), .coreR(coreR),
    .outValid(outValid), .outReady(outReady), .outR(outR), .outX(outX),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;

  // Core model and reference state
  int          doneAt = -100;
  logic [15:0] doneX = '0;
  logic        coreEn = 1'b1;
  logic        spur = 1'b0;
  logic [15:0] pushQ[$];
  logic [15:0] flightX = '0;
  logic [17:0] expR = '0;
  logic        flight = 1'b0, held = 1'b0, expStart = 1'b0, toErr = 1'b0;
  int          wStart = 0, pushedCnt = 0, acceptedCnt = 0, startCount = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s cyc=%0d got %h want %h", nm, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    coreDone = (coreEn && (cyc == doneAt)) || spur;
    coreR    = {2'b01, doneX};
  endtask

  always @(negedge clk) begin
    logic pushH, acceptH, flightBefore, inWait;
    int   nPrev;
    if (rst) begin
      pushQ.delete();
      flight = 1'b0; held = 1'b0; expStart = 1'b0; toErr = 1'b0;
      pushedCnt = 0; acceptedCnt = 0; doneAt = -100;
    end else begin
      pushH   = inValid && inReady;
      acceptH = outValid && outReady;
      chk("busy", 32'(busy), 32'(pushedCnt != acceptedCnt));
      if (!coreStart) chk("inReady", 32'(inReady), 32'(pushQ.size() < DEPTH));
      chk("coreStart", 32'(coreStart), 32'(expStart));
      chk("outValid", 32'(outValid), 32'(held));
      chk("timeoutErr", 32'(timeoutErr), 32'(toErr));
      if (coreStart) begin
        chk("startHasItem", 32'(pushQ.size() > 0), 32'd1);
        if (pushQ.size() > 0) begin
          chk("coreX", 32'(coreX), 32'(pushQ[0]));
          flightX = pushQ.pop_front();
        end
        flight = 1'b1;
        wStart = cyc + 1;
        startCount++;
        doneX = coreX;
        if (coreEn) doneAt = cyc + 12;
      end
      if (outValid) begin
        chk("outR", 32'(outR), 32'(expR));
        chk("outX", 32'(outX), 32'(flightX));
      end
      flightBefore = flight;
      nPrev  = pushQ.size();
      inWait = flight && !held && (cyc >= wStart);
      if (held) begin
        if (acceptH) begin
          held   = 1'b0;
          flight = 1'b0;
        end
      end else if (inWait && coreDone) begin
        held = 1'b1;
        expR = {2'b01, flightX};
      end
`ifdef COS_BATCH_TIMEOUT_EN
      else if (inWait && (cyc - wStart == TIMEOUT - 1)) begin
        held  = 1'b1;
        expR  = 18'h3FFFF;
        toErr = 1'b1;
      end
`endif
      expStart = (nPrev > 0) && (!flightBefore || acceptH);
      if (pushH) begin
        pushQ.push_back(inX);
        pushedCnt++;
      end
      if (acceptH) acceptedCnt++;
    end
  end

  task automatic drain(input string nm, input int lim);
    inValid = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < lim && (busy || outValid); i++) step();
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic waitOut(input string nm, input int lim);
    for (int i = 0; i < lim && !outValid; i++) step();
    chk(nm, 32'(outValid), 32'd1);
  endtask

  initial begin
    int n, s0;
    rst = 1'b1; inValid = 1'b0; inX = '0; outReady = 1'b1; coreDone = 1'b0; coreR = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rstInReady", 32'(inReady), 32'd1);
    chk("rstCoreX", 32'(coreX), 32'd0);
    chk("rstOutR", 32'(outR), 32'd0);
    chk("rstOutX", 32'(outX), 32'd0);
    chk("rstBusy", 32'(busy), 32'd0);

    // Single item
    inX = 16'h1234; inValid = 1'b1; n = cyc;
    step();
    inValid = 1'b0;
    for (int i = 0; i < 10 && !coreStart; i++) step();
    chk("startLatency", 32'(cyc - n), 32'd2);
    chk("singleCoreX", 32'(coreX), 32'h1234);
    waitOut("singleWait", 40);
    chk("singleOutR", 32'(outR), 32'h11234);
    chk("singleOutX", 32'(outX), 32'h1234);
    drain("singleIdle", 10);

    // Fill: five back-to-back pushes, FIFO full while item 1 waits on the core
    for (int k = 0; k < 5; k++) begin
      inX = 16'hA000 + 16'(k); inValid = 1'b1;
      for (int g = 0; g < 100 && !inReady; g++) step();
      step();
    end
    inValid = 1'b0;
    chk("fillFull", 32'(inReady), 32'd0);
    drain("fillDrain", 400);

    // Backpressure
    outReady = 1'b0;
    inX = 16'hB000; inValid = 1'b1; step();
    inX = 16'hB001; step();
    inValid = 1'b0;
    waitOut("bpWait", 40);
    s0 = startCount;
    repeat (20) step();
    chk("bpNoStart", 32'(startCount - s0), 32'd0);
    chk("bpHeldR", 32'(outR), 32'h1B000);
    outReady = 1'b1;
    step();
    chk("bpRestart", 32'(coreStart), 32'd1);
    drain("bpDrain", 100);

    // Spurious done while idle
    spur = 1'b1; step(); spur = 1'b0; step();
    chk("spurOutValid", 32'(outValid), 32'd0);
    chk("spurBusy", 32'(busy), 32'd0);

    // Reset while the first of four items is in WAIT
    for (int k = 0; k < 4; k++) begin
      inX = 16'hD000 + 16'(k); inValid = 1'b1; step();
    end
    inValid = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rstMidInReady", 32'(inReady), 32'd1);
    chk("rstMidOutValid", 32'(outValid), 32'd0);
    chk("rstMidCoreX", 32'(coreX), 32'd0);
    chk("rstMidBusy", 32'(busy), 32'd0);
    s0 = startCount;
    repeat (20) step();
    chk("rstMidNoStart", 32'(startCount - s0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      inValid  = 1'($urandom_range(0, 1));
      inX      = 16'($urandom);
      outReady = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("randDrain", 500);

`ifdef COS_BATCH_TIMEOUT_EN
    // Silent core: timeout result, then a normal item keeps the sticky flag
    coreEn = 1'b0;
    inX = 16'hC0DE; inValid = 1'b1; outReady = 1'b0; step();
    inValid = 1'b0;
    waitOut("toWait", TIMEOUT + 20);
    chk("toOutR", 32'(outR), 32'h3FFFF);
    chk("toOutX", 32'(outX), 32'hC0DE);
    chk("toErr", 32'(timeoutErr), 32'd1);
    drain("toDrain", 10);
    coreEn = 1'b1;
    inX = 16'h0042; inValid = 1'b1; step();
    drain("toNormalDrain", 100);
    chk("toSticky", 32'(timeoutErr), 32'd1);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
